// File: rtl/data_memory_be_pkg.sv
// Shared defaults and state type for the byte-enabled CPU data memory.
package CPU_package;
  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_BYTE_WIDTH    = 8;

  typedef enum logic {INIT, READY} mem_state_t;
endpackage

// File: rtl/data_memory_be_array.sv
// Plain synchronous word array with per-lane write strobes and a combinational read mux.
module data_memory_array #(
  parameter int DATA_WIDTH    = 16,
  parameter int BYTE_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256,
  localparam int NUM_LANES    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                     clock,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [NUM_LANES-1:0]     byte_enable,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0]    read_data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] Memories [DEPTH];

  // Addresses are range-checked by the parent; only the index bits reach the array.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (write_enable && byte_enable[i]) begin
        Memories[write_address[IDX_W-1:0]][i*BYTE_WIDTH +: BYTE_WIDTH] <=
          write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign read_data = Memories[read_address[IDX_W-1:0]];
endmodule

// File: rtl/data_memory_be.sv
// Byte-enabled data memory: clear sequencer FSM, write-first forwarding, registered read.
module data_memory_be
  import CPU_package::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int BYTE_WIDTH    = DEFAULT_BYTE_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DEPTH         = 256,
  localparam int NUM_LANES    = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     Clear_Request,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic                     Write_Enable,
  input  logic [NUM_LANES-1:0]     Byte_Enable,
  input  logic [DATA_WIDTH-1:0]    DATA_WRITE,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic                     Read_Enable,
  output logic [DATA_WIDTH-1:0]    DATA_READ,
  output logic                     Read_Valid,
  output logic                     Address_Error,
  output logic                     Ready,
  output mem_state_t               debug_state
);
  localparam int CNT_W = ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_width_check
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DEPTH < 2 || DEPTH > 2**ADDRESS_WIDTH) begin : g_depth_check
    $error("DEPTH must lie in 2 .. 2**ADDRESS_WIDTH");
  end

  mem_state_t state_q, state_d;
  logic [CNT_W-1:0] init_count_q, init_count_d;

  logic                     arr_we;
  logic [ADDRESS_WIDTH-1:0] arr_waddr;
  logic [NUM_LANES-1:0]     arr_be;
  logic [DATA_WIDTH-1:0]    arr_wdata;
  logic [DATA_WIDTH-1:0]    arr_rdata;
  logic [DATA_WIDTH-1:0]    merged;

  logic accept, wr_in_range, rd_in_range, wr_ok, rd_req, wr_err, rd_err;

  // Handshake: a request is taken on the rising edge where Ready=1 and Clear_Request=0;
  // there is no backpressure, Read_Valid qualifies DATA_READ for exactly one cycle.
  assign accept      = (state_q == READY) && !Clear_Request;
  assign wr_in_range = {1'b0, write_address} < DEPTH_C;
  assign rd_in_range = {1'b0, read_address} < DEPTH_C;
  assign wr_ok       = accept && Write_Enable && wr_in_range;
  assign wr_err      = accept && Write_Enable && !wr_in_range;
  assign rd_req      = accept && Read_Enable;
  assign rd_err      = rd_req && !rd_in_range;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT;
      init_count_q <= '0;
    end else begin
      state_q      <= state_d;
      init_count_q <= init_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_count_d = init_count_q;
    arr_we       = 1'b0;
    arr_waddr    = write_address;
    arr_be       = Byte_Enable;
    arr_wdata    = DATA_WRITE;
    case (state_q)
      INIT: begin
        arr_we    = 1'b1;
        arr_waddr = init_count_q[ADDRESS_WIDTH-1:0];
        arr_be    = '1;
        arr_wdata = '0;
        if (Clear_Request) begin
          init_count_d = '0;
        end else if (init_count_q == LAST_C) begin
          state_d      = READY;
          init_count_d = '0;
        end else begin
          init_count_d = init_count_q + 1'b1;
        end
      end
      READY: begin
        arr_we = wr_ok;
        if (Clear_Request) begin
          state_d      = INIT;
          init_count_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  data_memory_array #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BYTE_WIDTH   (BYTE_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DEPTH        (DEPTH)
  ) u_array (
    .clock        (clock),
    .write_enable (arr_we),
    .write_address(arr_waddr),
    .byte_enable  (arr_be),
    .write_data   (arr_wdata),
    .read_address (read_address),
    .read_data    (arr_rdata)
  );

  // Write-first: lanes being written to the read address this cycle take the new bytes.
  always_comb begin
    merged = arr_rdata;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_ok && (write_address == read_address) && Byte_Enable[i]) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      DATA_READ     <= '0;
      Read_Valid    <= 1'b0;
      Address_Error <= 1'b0;
    end else begin
      Read_Valid    <= rd_req;
      Address_Error <= rd_err || wr_err;
      if (rd_req) begin
        DATA_READ <= rd_in_range ? merged : '0;
      end
    end
  end

  assign Ready       = (state_q == READY);
  assign debug_state = state_q;
endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: default instance plus a DEPTH=200 instance on shared inputs.
module tb_data_memory_be;
  import CPU_package::*;

  logic        clock;
  logic        reset_n;
  logic        Clear_Request;
  logic [7:0]  write_address;
  logic        Write_Enable;
  logic [1:0]  Byte_Enable;
  logic [15:0] DATA_WRITE;
  logic [7:0]  read_address;
  logic        Read_Enable;

  logic [15:0] DATA_READ, b_DATA_READ;
  logic        Read_Valid, b_Read_Valid;
  logic        Address_Error, b_Address_Error;
  logic        Ready, b_Ready;
  mem_state_t  debug_state, b_debug_state;

  int passed = 0;
  int total  = 0;
  int nm, nb;
  logic rv_seen;

  data_memory_be u_dut (
    .clock(clock), .reset_n(reset_n), .Clear_Request(Clear_Request),
    .write_address(write_address), .Write_Enable(Write_Enable), .Byte_Enable(Byte_Enable),
    .DATA_WRITE(DATA_WRITE), .read_address(read_address), .Read_Enable(Read_Enable),
    .DATA_READ(DATA_READ), .Read_Valid(Read_Valid), .Address_Error(Address_Error),
    .Ready(Ready), .debug_state(debug_state)
  );

  data_memory_be #(.DEPTH(200)) u_d200 (
    .clock(clock), .reset_n(reset_n), .Clear_Request(Clear_Request),
    .write_address(write_address), .Write_Enable(Write_Enable), .Byte_Enable(Byte_Enable),
    .DATA_WRITE(DATA_WRITE), .read_address(read_address), .Read_Enable(Read_Enable),
    .DATA_READ(b_DATA_READ), .Read_Valid(b_Read_Valid), .Address_Error(b_Address_Error),
    .Ready(b_Ready), .debug_state(b_debug_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input logic we, input logic [7:0] wa, input logic [1:0] be,
                       input logic [15:0] wd, input logic re, input logic [7:0] ra,
                       input logic clr);
    Write_Enable  = we;
    write_address = wa;
    Byte_Enable   = be;
    DATA_WRITE    = wd;
    Read_Enable   = re;
    read_address  = ra;
    Clear_Request = clr;
    tick();
    Write_Enable  = 1'b0;
    Read_Enable   = 1'b0;
    Clear_Request = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] wa, input logic [1:0] be, input logic [15:0] wd);
    cycle(1'b1, wa, be, wd, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] ra);
    cycle(1'b0, 8'h00, 2'b00, 16'h0000, 1'b1, ra, 1'b0);
  endtask

  // Counts edges until each instance reports Ready; drops any held requests after 150 edges.
  task automatic wait_ready(input string tag, input int exp_main, input int exp_b);
    int n;
    n  = 0;
    nm = -1;
    nb = -1;
    while (nm < 0 && n < 1000) begin
      tick();
      n++;
      if (Read_Valid || Address_Error) rv_seen = 1'b1;
      if (nb < 0 && b_Ready) nb = n;
      if (Ready) nm = n;
      if (n == 150) begin
        Write_Enable = 1'b0;
        Read_Enable  = 1'b0;
      end
    end
    check({tag, "_main_cycles"}, 32'(nm), 32'(exp_main));
    check({tag, "_d200_cycles"}, 32'(nb), 32'(exp_b));
  endtask

  initial begin
    reset_n       = 1'b0;
    Clear_Request = 1'b0;
    write_address = 8'h00;
    Write_Enable  = 1'b0;
    Byte_Enable   = 2'b00;
    DATA_WRITE    = 16'h0000;
    read_address  = 8'h00;
    Read_Enable   = 1'b0;
    rv_seen       = 1'b0;
    #23;
    check("reset_data_read", 32'(DATA_READ), 32'h0);
    check("reset_read_valid", 32'(Read_Valid), 32'h0);
    check("reset_addr_err", 32'(Address_Error), 32'h0);
    check("reset_ready", 32'(Ready), 32'h0);
    check("reset_state", 32'(debug_state), 32'(INIT));

    // Power-up sweep with requests held during INIT; they must be ignored.
    tick();
    reset_n       = 1'b1;
    Write_Enable  = 1'b1;
    write_address = 8'h03;
    Byte_Enable   = 2'b11;
    DATA_WRITE    = 16'hFFFF;
    Read_Enable   = 1'b1;
    read_address  = 8'h03;
    wait_ready("powerup", 256, 200);
    Write_Enable = 1'b0;
    Read_Enable  = 1'b0;
    check("init_no_strobes", 32'(rv_seen), 32'h0);
    check("ready_state", 32'(debug_state), 32'(READY));

    do_read(8'h00);
    check("rd0_data", 32'(DATA_READ), 32'h0);
    check("rd0_valid", 32'(Read_Valid), 32'h1);
    do_read(8'h80);
    check("rd128_data", 32'(DATA_READ), 32'h0);
    check("rd128_valid", 32'(Read_Valid), 32'h1);
    do_read(8'hFF);
    check("rd255_data", 32'(DATA_READ), 32'h0);
    check("rd255_valid", 32'(Read_Valid), 32'h1);
    check("rd255_addr_err", 32'(Address_Error), 32'h0);
    tick();
    check("idle_valid_low", 32'(Read_Valid), 32'h0);
    do_read(8'h03);
    check("init_write_ignored", 32'(DATA_READ), 32'h0);

    // Byte-lane merge across two writes.
    do_write(8'h10, 2'b11, 16'hA5C3);
    check("write_no_valid", 32'(Read_Valid), 32'h0);
    do_write(8'h10, 2'b10, 16'h1200);
    do_read(8'h10);
    check("lane_merge", 32'(DATA_READ), 32'h12C3);
    tick();
    check("hold_data", 32'(DATA_READ), 32'h12C3);
    check("hold_valid_low", 32'(Read_Valid), 32'h0);

    // Write-first forwarding on a same-cycle read.
    do_write(8'h20, 2'b11, 16'h1111);
    cycle(1'b1, 8'h20, 2'b01, 16'hBEEF, 1'b1, 8'h20, 1'b0);
    check("fwd_data", 32'(DATA_READ), 32'h11EF);
    check("fwd_valid", 32'(Read_Valid), 32'h1);
    do_read(8'h20);
    check("fwd_written", 32'(DATA_READ), 32'h11EF);
    cycle(1'b1, 8'h20, 2'b00, 16'hFFFF, 1'b1, 8'h20, 1'b0);
    check("be0_noop_fwd", 32'(DATA_READ), 32'h11EF);
    do_read(8'h20);
    check("be0_noop_mem", 32'(DATA_READ), 32'h11EF);

    // Out-of-range handling on the DEPTH=200 instance.
    do_write(8'h48, 2'b11, 16'h1234);
    do_read(8'h48);
    check("d200_rd48", 32'(b_DATA_READ), 32'h1234);
    do_read(8'hC8);
    check("d200_oor_data", 32'(b_DATA_READ), 32'h0);
    check("d200_oor_valid", 32'(b_Read_Valid), 32'h1);
    check("d200_oor_err", 32'(b_Address_Error), 32'h1);
    check("main_c8_no_err", 32'(Address_Error), 32'h0);
    do_write(8'hC8, 2'b11, 16'hDEAD);
    check("d200_oor_wr_err", 32'(b_Address_Error), 32'h1);
    check("d200_oor_wr_novalid", 32'(b_Read_Valid), 32'h0);
    tick();
    check("d200_err_strobe_low", 32'(b_Address_Error), 32'h0);
    do_read(8'h48);
    check("d200_rd48_unchanged", 32'(b_DATA_READ), 32'h1234);
    check("d200_rd48_no_err", 32'(b_Address_Error), 32'h0);
    do_read(8'hC8);
    check("main_c8_written", 32'(DATA_READ), 32'hDEAD);

    // Clear request wins over same-cycle write and read.
    do_write(8'h05, 2'b11, 16'hFFFF);
    do_read(8'h05);
    check("pre_clear_rd5", 32'(DATA_READ), 32'hFFFF);
    cycle(1'b1, 8'h06, 2'b11, 16'h7777, 1'b1, 8'h05, 1'b1);
    check("clear_ready_low", 32'(Ready), 32'h0);
    check("clear_state", 32'(debug_state), 32'(INIT));
    check("clear_no_valid", 32'(Read_Valid), 32'h0);
    check("clear_hold_data", 32'(DATA_READ), 32'hFFFF);
    repeat (50) tick();
    cycle(1'b0, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h00, 1'b1);
    rv_seen = 1'b0;
    wait_ready("clear_restart", 256, 200);
    check("clear_sweep_no_strobes", 32'(rv_seen), 32'h0);
    do_read(8'h05);
    check("cleared_rd5", 32'(DATA_READ), 32'h0);

    // Asynchronous reset in the middle of a sweep.
    do_write(8'h07, 2'b11, 16'h5A5A);
    do_read(8'h07);
    check("pre_reset_rd7", 32'(DATA_READ), 32'h5A5A);
    cycle(1'b0, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h00, 1'b1);
    repeat (100) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_data", 32'(DATA_READ), 32'h0);
    check("async_rst_d200_data", 32'(b_DATA_READ), 32'h0);
    check("async_rst_valid", 32'(Read_Valid), 32'h0);
    check("async_rst_ready", 32'(Ready), 32'h0);
    tick();
    reset_n = 1'b1;
    wait_ready("rst_release", 256, 200);
    do_read(8'h07);
    check("post_reset_rd7", 32'(DATA_READ), 32'h0);
    check("post_reset_valid", 32'(Read_Valid), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
Parametrised successor to the CPU data memory: single-clock, one write port and one read port, with per-byte write enables. Adds write-first read-during-write forwarding, a registered read with a valid strobe, and out-of-range address detection. A hardware clear sequencer zeroes the whole array after reset or on request. Sits between the CPU load/store stage and the memory array; the CPU stalls on Ready low.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, width of one byte lane.
ADDRESS_WIDTH, 8, address bus width.
DEPTH, 256, number of words; 2 <= DEPTH <= 2**ADDRESS_WIDTH (non-power-of-2 allowed).
NUM_LANES is derived as DATA_WIDTH/BYTE_WIDTH and is not overridable.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
Clear_Request  input  1  one-cycle pulse; restarts the zeroing sweep.
write_address  input  ADDRESS_WIDTH  write word address.
Write_Enable  input  1  write request.
Byte_Enable  input  NUM_LANES  lane i covers DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH].
DATA_WRITE  input  DATA_WIDTH  write data.
read_address  input  ADDRESS_WIDTH  read word address.
Read_Enable  input  1  read request.
DATA_READ  output  DATA_WIDTH  registered read data.
Read_Valid  output  1  one-cycle strobe: DATA_READ was updated this cycle.
Address_Error  output  1  one-cycle strobe: an accepted request addressed >= DEPTH.
Ready  output  1  high when requests are accepted.

Behaviour:
- Reset (reset_n low, asynchronous): state=INIT, Init_Count=0, Ready=0, DATA_READ=0, Read_Valid=0, Address_Error=0. Array contents are not reset directly; the INIT sweep clears them.
- FSM states are INIT and READY.
- INIT: each cycle writes 0 to Memories[Init_Count] and increments Init_Count. The cycle that writes DEPTH-1 transitions to READY.
  - Ready first samples 1 exactly DEPTH cycles after the first clock edge with reset_n high.
  - In INIT, Write_Enable and Read_Enable are ignored; Read_Valid=0 and Address_Error=0.
  - Clear_Request during INIT restarts Init_Count at 0.
- READY: Ready=1. Clear_Request moves to INIT with Init_Count=0. In that same cycle, writes and reads are dropped (clear wins) and Read_Valid stays 0 next cycle.
- Write (READY, Write_Enable=1, write_address<DEPTH): only lanes with Byte_Enable[i]=1 are updated. Byte_Enable=0 is a legal no-op write.
- Read (READY, Read_Enable=1): 1-cycle latency. DATA_READ and Read_Valid=1 are registered at the next edge. With no accepted read, Read_Valid=0 and DATA_READ holds its previous value.
- Read-during-write, same cycle and same in-range address: write-first. DATA_READ returns the merged word (new bytes for enabled lanes, old bytes otherwise), not the stale word.
- Out-of-range read (read_address>=DEPTH): DATA_READ=0, Read_Valid=1, Address_Error=1 next cycle.
- Out-of-range write: array unchanged, Address_Error=1 next cycle.
- Address_Error is the OR of the read and write error conditions.
- Reset asserted mid-sweep or mid-read: outputs go to reset values immediately; the sweep restarts when reset_n releases.
- Init_Count width is ADDRESS_WIDTH+1 so DEPTH=2**ADDRESS_WIDTH does not wrap early.

Decomposition:
- CPU_package holds: DATA_WIDTH and ADDRESS_WIDTH defaults, the BYTE_WIDTH constant, and typedef enum logic {INIT, READY} mem_state_t.
- One sub-module, data_memory_array: plain synchronous array with per-lane write and unregistered read-address mux. The parent holds the FSM, the forwarding merge and the output registers. The elaboration-time check DATA_WIDTH % BYTE_WIDTH == 0 lives in the parent.

Test Plan:
- Release reset_n at t0 with defaults -> Ready=0 for 256 cycles, then Ready=1. A read of addresses 0, 128 and 255 returns 0x0000 with Read_Valid pulsing 1 cycle after each request.
- Write 0xA5C3 to addr 0x10 with Byte_Enable=2'b11, then write 0x1200 to addr 0x10 with Byte_Enable=2'b10, then read 0x10 -> DATA_READ=0x12C3 one cycle after the read.
- Same cycle: write 0xBEEF, Byte_Enable=2'b01, to addr 0x20 (holding 0x1111) and read addr 0x20 -> DATA_READ=0x11EF next cycle, with Read_Valid=1.
- DEPTH=200: read addr 0xC8 -> DATA_READ=0, Read_Valid=1, Address_Error=1. A write to 0xC8 -> Address_Error=1, and a read of 0x48 is unchanged.
- After writing 0xFFFF to addr 5, pulse Clear_Request together with a write to addr 6 -> Ready=0 next cycle, write dropped. After DEPTH cycles Ready=1 and addr 5 reads 0.
- Assert reset_n low mid-sweep (Init_Count=100) -> outputs at reset values asynchronously. After release, Ready rises exactly DEPTH cycles later.
